// File: rtl/store_buffer.sv
// Store buffer between execute and data RAM: queues stores, drains them in order
// through a valid/ack handshake and forwards pending data to loads.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [DATA_W-1:0]        st_data,
    output logic                     st_ready,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     ld_hit,
    output logic [DATA_W-1:0]        ld_data,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic                     mem_ack,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic [PTR_W-1:0]  fwd_idx;
    logic              full;
    logic              push;
    logic              pop;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign st_ready  = !full;
    assign mem_we    = !empty;
    assign push      = st_valid && !full;
    assign pop       = mem_we && mem_ack;
    assign count     = count_q;
    assign mem_addr  = mem_we ? addr_q[rd_ptr] : '0;
    assign mem_wdata = mem_we ? data_q[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (push) begin
                wr_ptr          <= wr_ptr + PTR_W'(1);
                valid_q[wr_ptr] <= 1'b1;
            end
            // push and pop never address the same slot: push needs not-full, pop needs not-empty
            if (pop) begin
                rd_ptr          <= rd_ptr + PTR_W'(1);
                valid_q[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset; it is only observed through valid/count gating.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= st_addr;
            data_q[wr_ptr] <= st_data;
        end
    end

    // Scan oldest to youngest so the last match (youngest store) wins.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        fwd_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = rd_ptr + PTR_W'(k);
            if (valid_q[fwd_idx] && (addr_q[fwd_idx] == ld_addr)) begin
                ld_hit  = 1'b1;
                ld_data = data_q[fwd_idx];
            end
        end
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write-side companion to the write-back path: queues CPU store requests (address + 8-bit data) and drains them to the data RAM one at a time through a valid/ack handshake.
- Loads probe the buffer so that a read of a not-yet-drained address returns the pending store value. The load mux selects this value over RAM data when ld_hit is high.
- Sits between the execute stage and data memory.

Parameters:
- DEPTH, 4, number of store entries; must be a power of 2, at least 2.
- ADDR_W, 8, address width.
- DATA_W, 8, data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- st_valid  input  1  store request from control (mem write).
- st_addr  input  ADDR_W  store address.
- st_data  input  DATA_W  store data from register file.
- st_ready  output  1  buffer can accept a store this cycle (= not full).
- ld_addr  input  ADDR_W  address of the current load, probed combinationally.
- ld_hit  output  1  a valid entry matches ld_addr.
- ld_data  output  DATA_W  data of the youngest matching entry; 0 when no hit.
- mem_we  output  1  head entry is being offered to RAM (= not empty).
- mem_addr  output  ADDR_W  head entry address; 0 when empty.
- mem_wdata  output  DATA_W  head entry data; 0 when empty.
- mem_ack  input  1  RAM accepted the offered write this cycle.
- count  output  $clog2(DEPTH)+1  number of valid entries.
- empty  output  1  count == 0.

Behaviour:
- Reset (async assert, sync release by clk edge):
  - Pointers, count and entry valid bits cleared.
  - st_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, ld_hit=0, ld_data=0, count=0, empty=1.
  - Reset mid-drain discards all pending stores; no write completes after reset asserts.
- Storage: circular FIFO with wr_ptr and rd_ptr of $clog2(DEPTH) bits each, wrapping modulo DEPTH. count tracks occupancy from 0 to DEPTH.
- Push: fires when st_valid && st_ready at a clk edge. Entry written at wr_ptr; wr_ptr increments; count increments.
  - st_valid while full is ignored; the store stalls upstream until st_ready returns.
- Drain:
  - mem_we, mem_addr and mem_wdata are driven from the head entry whenever count>0.
  - Pop fires on a clk edge when mem_we && mem_ack: rd_ptr increments, count decrements.
  - mem_ack while mem_we=0 is ignored.
  - The offered values hold stable until acked.
- Latency: a push into an empty buffer appears on mem_we/mem_addr/mem_wdata in the following cycle. Each subsequent entry is offered the cycle after the previous ack.
- Simultaneous push and pop:
  - When not full, both happen; count is unchanged; pointers both advance.
  - When full, st_ready=0, so the push is rejected even though a pop occurs that cycle. st_ready becomes 1 the next cycle.
- st_ready is combinational from count only; it does not depend on mem_ack.
- Forwarding:
  - Purely combinational compare of ld_addr against all valid entries.
  - On multiple matches, the youngest entry (closest to wr_ptr) wins.
  - A store being pushed in the same cycle is not visible to forwarding.
  - An entry being popped in the same cycle is still visible.
  - On no match: ld_hit=0, ld_data=0.
- Arithmetic: pointer and count updates are exact; no overflow is possible given the full/empty gating.

Test Plan:
- Reset then idle: after rst_n release, hold st_valid=0 for 5 cycles -> count=0, empty=1, st_ready=1, mem_we=0, mem_addr=0.
- Single store with 3-cycle-delayed ack:
  - Push addr 0x10, data 0xAB.
  - Next cycle: mem_we=1, mem_addr=0x10, mem_wdata=0xAB.
  - Outputs stay stable until mem_ack; the cycle after the ack, empty=1.
- Fill and overflow (DEPTH=4, mem_ack=0):
  - Push 5 stores with addresses 0x01..0x05 -> count=4, st_ready=0, 5th store not accepted.
  - Raise mem_ack for one cycle -> head 0x01 popped, count=3; st_ready=1 the next cycle.
- Forwarding priority (mem_ack=0):
  - Push (0x20,0x11), (0x30,0x22), (0x20,0x33).
  - ld_addr=0x20 -> ld_hit=1, ld_data=0x33.
  - ld_addr=0x30 -> ld_hit=1, ld_data=0x22.
  - ld_addr=0x40 -> ld_hit=0, ld_data=0.
- Simultaneous push/pop and wrap: mem_ack held at 1 while 10 consecutive stores are pushed -> count stays at 1 after the first push. mem_addr sequence matches push order across pointer wrap with no loss or duplication.
- Async reset mid-drain: with count=3, pull rst_n low between clk edges -> outputs return to reset values immediately, without waiting for a clock edge. After release, no stale mem_we is asserted.
